load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
MEM-stage initiator that turns CPU load/store requests (byte/half/word, signed/unsigned) into word-aligned accesses on the data-memory port (addr, Mem_rd, Mem_wr, Write_data, Read_data).
- Loads: one memory read, result registered.
- Word stores: single-cycle write.
- Sub-word stores: two-cycle read-modify-write; the pipeline is stalled during the RMW accept cycle.

Parameters:
- ADDR_W, 32, byte-address width on both the CPU and memory sides.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present this cycle
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend loads when 1; ignored for word and for stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  CPU must hold all req_* inputs stable while high
- load_data  out  32  registered, extracted and extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- misaligned  out  1  one-cycle pulse, access suppressed (feature only)
- mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable, captured on the memory's clock edge
- mem_wdata  out  32  write word
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- States: IDLE, RMW_WR.
- Reset (synchronous): state = IDLE; load_data = 0, load_valid = 0, misaligned = 0. While reset is high, mem_rd = mem_wr = 0 and stall = 0.
- IDLE, no req_valid: mem_rd = mem_wr = 0; load_valid and misaligned are 0 on the next cycle.
- IDLE, load:
  - Same cycle: mem_rd = 1.
  - Next edge: load_data <= lane extracted by req_addr[1:0] (byte) or req_addr[1] (half). Little-endian: byte 0 = bits [7:0].
  - Extension: zero-extend, or sign-extend when req_signed. load_valid <= 1.
  - Latency 1, stall = 0.
- IDLE, store word: same cycle mem_wr = 1, mem_wdata = req_wdata, stall = 0. No state change.
- IDLE, store byte/half:
  - Accept cycle: mem_rd = 1, stall = 1 (combinational).
  - Next edge: latch mem_rdata, lane mask, shifted data and word address; go to RMW_WR.
- RMW_WR:
  - mem_wr = 1; mem_addr = latched address; mem_wdata = (old & ~mask) | (new & mask).
  - stall = 0. All req_* inputs are ignored in this cycle. Return to IDLE.
- load_valid and misaligned are never high in the same cycle. load_data holds its value between loads.
- Reset asserted in RMW_WR: the write is aborted; the memory word is unchanged.
- Back-to-back requests: a new request is accepted in any IDLE cycle, including the cycle right after RMW_WR.
- Address bits above ADDR_W are not present. Wrap-around is the memory's concern.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A half with addr[0] = 1, or a word with addr[1:0] != 0, is misaligned.
  - Misaligned requests: mem_rd = mem_wr = 0, stall = 0; misaligned <= 1 for one cycle; load_valid stays 0; load_data unchanged.
- MISALIGN_TRAP_EN undefined:
  - misaligned is tied to 0.
  - Low address bits below natural alignment are ignored: half uses addr[1], word uses lane 0. The access proceeds normally.

Test Plan:
- Bench memory word0 = 32'h8000_00F2, word1 = 12. Load word at addr 4 -> load_valid pulse one cycle later, load_data = 12, stall never high.
- Load byte signed at addr 0 -> load_data = 32'hFFFF_FFF2. The same load unsigned -> 32'h0000_00F2. Load half signed at addr 2 -> 32'hFFFF_8000.
- Store byte 8'hAB at addr 1 over word 32'h1122_3344:
  - stall high exactly one cycle; mem_rd then mem_wr on consecutive cycles.
  - Word becomes 32'h1122_AB44; next-cycle request accepted.
- Store half 16'hBEEF at addr 6, then store word 32'hDEAD_0000 at addr 8 held behind it -> word1 = 32'hBEEF_xxxx (upper half), word2 written the cycle after RMW_WR.
- Reset asserted during RMW_WR of a byte store -> no mem_wr; memory unchanged; load_valid = 0, load_data = 0 next cycle.
- With MISALIGN_TRAP_EN, load word at addr 2 -> no mem_rd, misaligned pulse, load_valid = 0. Without it, the same request returns word0.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-aligned memory port, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN suppresses misaligned half/word accesses and pulses 'misaligned'.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t state, state_next;

    logic              is_byte, is_half, is_word;
    logic              req_misaligned;
    logic              req_live, accept;
    logic              do_load, do_store_word, do_store_sub, do_trap;
    logic [4:0]        lane_shift;
    logic [31:0]       lane_rdata, load_ext;
    logic [31:0]       lane_mask, lane_wdata;
    logic [ADDR_W-1:0] word_addr;

    logic [31:0]       rmw_old, rmw_mask, rmw_data;
    logic [ADDR_W-1:0] rmw_addr;

    assign is_byte   = (req_size == 2'b00);
    assign is_half   = (req_size == 2'b01);
    assign is_word   = req_size[1];
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign req_misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    assign req_live      = (state == IDLE) && req_valid && !reset;
    assign accept        = req_live && !req_misaligned;
    assign do_trap       = req_live && req_misaligned;
    assign do_load       = accept && !req_wr;
    assign do_store_word = accept && req_wr && is_word;
    assign do_store_sub  = accept && req_wr && !is_word;

    // Half lanes follow addr[1] only, byte lanes follow addr[1:0]; words always use lane 0.
    assign lane_shift = is_word ? 5'd0 :
                        is_half ? {req_addr[1], 4'b0000} : {req_addr[1:0], 3'b000};

    assign lane_rdata = mem_rdata >> lane_shift;

    always_comb begin
        load_ext = mem_rdata;
        if (is_byte)
            load_ext = {{24{req_signed & lane_rdata[7]}}, lane_rdata[7:0]};
        else if (is_half)
            load_ext = {{16{req_signed & lane_rdata[15]}}, lane_rdata[15:0]};
    end

    assign lane_mask  = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    assign lane_wdata = (req_wdata & (is_half ? 32'h0000_FFFF : 32'h0000_00FF)) << lane_shift;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = word_addr;
        mem_wdata  = req_wdata;
        case (state)
            IDLE: begin
                if (do_load)
                    mem_rd = 1'b1;
                if (do_store_word)
                    mem_wr = 1'b1;
                if (do_store_sub) begin
                    mem_rd     = 1'b1;
                    stall      = 1'b1;
                    state_next = RMW_WR;
                end
            end
            RMW_WR: begin
                // Gating with reset aborts the write so the memory word stays intact.
                mem_wr     = !reset;
                mem_addr   = rmw_addr;
                mem_wdata  = (rmw_old & ~rmw_mask) | (rmw_data & rmw_mask);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            rmw_old    <= 32'd0;
            rmw_mask   <= 32'd0;
            rmw_data   <= 32'd0;
            rmw_addr   <= '0;
        end else begin
            state      <= state_next;
            load_valid <= do_load;
            misaligned <= do_trap;
            if (do_load)
                load_data <= load_ext;
            if (do_store_sub) begin
                rmw_old  <= mem_rdata;
                rmw_mask <= lane_mask;
                rmw_data <= lane_wdata;
                rmw_addr <= word_addr;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference model predicts loads and memory
// writes, a negedge monitor compares them; honours MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_wr, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, misaligned, mem_rd, mem_wr;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } ev_t;

    ev_t resp_q[$];
    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t mon_e;

    logic [31:0] ref_mem[16];
    logic [31:0] bmem[16];
    logic [31:0] last_load;
    logic        mem_init;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench data memory: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) bmem[k] <= ref_mem[k];
        end else if (mem_wr) begin
            bmem[mem_addr[5:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = bmem[mem_addr[5:2]];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn, input logic [5:0] addr);
        logic [31:0] v;
        int b;
        v = w;
        if (size == 2'b00) begin
            b = int'(addr[1:0]);
            v = (w >> (8 * b)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'd256;
        end else if (size == 2'b01) begin
            b = addr[1] ? 2 : 0;
            v = (w >> (8 * b)) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [5:0] addr, input logic [31:0] d);
        logic [7:0] by[4];
        int b;
        for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
        if (size == 2'b00) begin
            by[addr[1:0]] = d[7:0];
        end else if (size == 2'b01) begin
            b = addr[1] ? 2 : 0;
            by[b]     = d[7:0];
            by[b + 1] = d[15:8];
        end else begin
            for (int k = 0; k < 4; k++) by[k] = d[8*k +: 8];
        end
        return {by[3], by[2], by[1], by[0]};
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] size, input logic [5:0] addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01) return addr[0];
        if (size[1])       return addr[1:0] != 2'b00;
        return 1'b0;
`else
        return (size == 2'b11) && (addr == 6'h3F) && 1'b0;
`endif
    endfunction

    // Issues one request at posedge+1 and returns at posedge+1 of the next cycle in which
    // a new request may be presented; expected events go to the scoreboard queues.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [5:0] addr, input logic [31:0] wdata);
        logic       mis, sub;
        logic [3:0] widx;
        logic [31:0] v, waddr;
        ev_t e;
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_signed = sgn;
        req_addr  = {26'd0, addr};
        req_wdata = wdata;
        mis   = ref_misaligned(size, addr);
        widx  = addr[5:2];
        waddr = {26'd0, addr[5:2], 2'b00};
        sub   = wr && !size[1] && !mis;
        if (mis) begin
            e = '{kind: 1'b1, addr: 32'd0, data: last_load, due: cyc + 1};
            resp_q.push_back(e);
        end else if (!wr) begin
            v = ref_load(ref_mem[widx], size, sgn, addr);
            last_load = v;
            e = '{kind: 1'b0, addr: 32'd0, data: v, due: cyc + 1};
            resp_q.push_back(e);
            e = '{kind: 1'b0, addr: waddr, data: 32'd0, due: cyc};
            rd_q.push_back(e);
        end else if (size[1]) begin
            ref_mem[widx] = wdata;
            e = '{kind: 1'b0, addr: waddr, data: wdata, due: cyc};
            wr_q.push_back(e);
        end else begin
            e = '{kind: 1'b0, addr: waddr, data: 32'd0, due: cyc};
            rd_q.push_back(e);
            v = ref_store(ref_mem[widx], size, addr, wdata);
            ref_mem[widx] = v;
            e = '{kind: 1'b0, addr: waddr, data: v, due: cyc + 1};
            wr_q.push_back(e);
        end
        #1;
        checkOutput("stall_accept", {31'd0, stall}, {31'd0, sub});
        @(posedge clk); #1;
        if (sub) begin
            // The write-back cycle ignores whatever the CPU presents.
            req_valid = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 3));
            req_addr  = {26'd0, 6'($urandom_range(0, 63))};
            req_wdata = $urandom;
            #1;
            checkOutput("stall_rmw", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic idleCycle();
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: every load/misaligned pulse, memory read and memory write is matched in order.
    always @(negedge clk) begin
        while (resp_q.size() > 0 && resp_q[0].due < cyc) begin
            mon_e = resp_q.pop_front();
            checkOutput("resp_missing_cycle", cyc, mon_e.due);
        end
        while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
            mon_e = rd_q.pop_front();
            checkOutput("rd_missing_cycle", cyc, mon_e.due);
        end
        while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
            mon_e = wr_q.pop_front();
            checkOutput("wr_missing_cycle", cyc, mon_e.due);
        end
        if (load_valid === 1'b1 && misaligned === 1'b1)
            checkOutput("valid_and_misaligned", 32'd1, 32'd0);
        if (load_valid === 1'b1 || misaligned === 1'b1) begin
            if (resp_q.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
            else begin
                mon_e = resp_q.pop_front();
                checkOutput("resp_kind", {31'd0, misaligned}, {31'd0, mon_e.kind});
                checkOutput("resp_cycle", cyc, mon_e.due);
                checkOutput("load_data", load_data, mon_e.data);
            end
        end
        if (mem_rd === 1'b1) begin
            if (rd_q.size() == 0) checkOutput("unexpected_mem_rd", 32'd1, 32'd0);
            else begin
                mon_e = rd_q.pop_front();
                checkOutput("rd_cycle", cyc, mon_e.due);
                checkOutput("rd_addr", mem_addr, mon_e.addr);
            end
        end
        if (mem_wr === 1'b1) begin
            if (wr_q.size() == 0) checkOutput("unexpected_mem_wr", 32'd1, 32'd0);
            else begin
                mon_e = wr_q.pop_front();
                checkOutput("wr_cycle", cyc, mon_e.due);
                checkOutput("wr_addr", mem_addr, mon_e.addr);
                checkOutput("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    initial begin
        ev_t e;
        ref_mem[0] = 32'h8000_00F2;
        ref_mem[1] = 32'd12;
        for (int k = 2; k < 16; k++) ref_mem[k] = $urandom;
        last_load  = 32'd0;
        mem_init   = 1'b1;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'd4;
        req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset checks");
        checkOutput("rst_load_data", load_data, 32'd0);
        checkOutput("rst_load_valid", {31'd0, load_valid}, 32'd0);
        checkOutput("rst_misaligned", {31'd0, misaligned}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        reset     = 1'b0;
        mem_init  = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed loads");
        applyStimulus(1'b0, 2'b10, 1'b0, 6'd4, 32'd0);
        checkOutput("ld_word4_valid", {31'd0, load_valid}, 32'd1);
        checkOutput("ld_word4", load_data, 32'd12);
        applyStimulus(1'b0, 2'b00, 1'b1, 6'd0, 32'd0);
        checkOutput("ld_byte_signed", load_data, 32'hFFFF_FFF2);
        applyStimulus(1'b0, 2'b00, 1'b0, 6'd0, 32'd0);
        checkOutput("ld_byte_unsigned", load_data, 32'h0000_00F2);
        applyStimulus(1'b0, 2'b01, 1'b1, 6'd2, 32'd0);
        checkOutput("ld_half_signed", load_data, 32'hFFFF_8000);
        applyStimulus(1'b0, 2'b10, 1'b0, 6'd2, 32'd0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis_pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("mis_no_valid", {31'd0, load_valid}, 32'd0);
        checkOutput("mis_data_held", load_data, 32'hFFFF_8000);
`else
        checkOutput("unaligned_word", load_data, 32'h8000_00F2);
`endif

        $display("[TB] directed stores");
        applyStimulus(1'b1, 2'b10, 1'b0, 6'd0, 32'h1122_3344);
        applyStimulus(1'b1, 2'b00, 1'b0, 6'd1, 32'h0000_00AB);
        applyStimulus(1'b0, 2'b10, 1'b0, 6'd0, 32'd0);
        checkOutput("st_byte_merge", load_data, 32'h1122_AB44);
        applyStimulus(1'b1, 2'b01, 1'b0, 6'd6, 32'h0000_BEEF);
        applyStimulus(1'b1, 2'b10, 1'b0, 6'd8, 32'hDEAD_0000);
        applyStimulus(1'b0, 2'b10, 1'b0, 6'd4, 32'd0);
        checkOutput("st_half_upper", load_data, 32'hBEEF_000C);
        applyStimulus(1'b0, 2'b10, 1'b0, 6'd8, 32'd0);
        checkOutput("st_word_behind", load_data, 32'hDEAD_0000);

        $display("[TB] reset during write-back");
        req_valid  = 1'b1;
        req_wr     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd1;
        req_wdata  = 32'h0000_0055;
        e = '{kind: 1'b0, addr: 32'd0, data: 32'd0, due: cyc};
        rd_q.push_back(e);
        #1;
        checkOutput("rst_rmw_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_rmw_no_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        last_load = 32'd0;
        checkOutput("rst_rmw_load_valid", {31'd0, load_valid}, 32'd0);
        checkOutput("rst_rmw_load_data", load_data, 32'd0);
        @(posedge clk); #1;

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idleCycle();
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        checkOutput("resp_q_drained", resp_q.size(), 32'd0);
        checkOutput("rd_q_drained", rd_q.size(), 32'd0);
        checkOutput("wr_q_drained", wr_q.size(), 32'd0);
        for (int k = 0; k < 16; k++) checkOutput("final_mem", bmem[k], ref_mem[k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
